// File: rtl/mem_cmd_port_p.sv
// Memory-side command port: parses header + address, streams WR_RES data to the FSM via a FIFO
// or RD data to the bus, and sequences CTRL / end-of-transfer acks. Optional watchdog: MEM_CMD_TIMEOUT_EN.
module mem_cmd_port_p #(
  parameter int ADDR_BYTES  = 3,
  parameter int KEY_BEATS   = 32,
  parameter int SHA_BEATS   = 32,
  parameter int AES_BEATS   = 16,
  parameter int DEPTH       = 4,
  parameter int TIMEOUT_CYC = 1024,
  localparam int MAXB = (KEY_BEATS > SHA_BEATS) ?
                        ((KEY_BEATS > AES_BEATS) ? KEY_BEATS : AES_BEATS) :
                        ((SHA_BEATS > AES_BEATS) ? SHA_BEATS : AES_BEATS),
  localparam int LW   = $clog2(MAXB + 1),
  localparam int AW   = 8 * ADDR_BYTES
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          bus_valid,
  input  logic [7:0]    bus_data,
  output logic          bus_ready,
  output logic          bus_out_valid,
  output logic [7:0]    bus_out_data,
  input  logic          bus_out_ready,
  output logic          fsm_wr_valid,
  output logic [7:0]    fsm_wr_data,
  input  logic          fsm_wr_ready,
  input  logic          fsm_rd_valid,
  input  logic [7:0]    fsm_rd_data,
  output logic          fsm_rd_ready,
  input  logic          txn_done,
  output logic          r_w,
  output logic          ena,
  output logic [LW-1:0] length,
  output logic          length_valid,
  output logic [AW-1:0] address,
  output logic          address_valid,
  output logic          ack_req,
  output logic [1:0]    ack_id,
  input  logic          ack_grant,
  output logic          err_timeout
);

  localparam int PW  = $clog2(DEPTH) + 1;
  localparam int ACW = $clog2(ADDR_BYTES + 1);
  localparam logic [1:0] OP_RD_KEY  = 2'd0;
  localparam logic [1:0] OP_RD_TEXT = 2'd1;
  localparam logic [1:0] OP_WR_RES  = 2'd2;
  localparam logic [1:0] OP_HASH    = 2'd3;
  localparam logic [1:0] ACK_CTRL   = 2'd3;

  typedef enum logic [2:0] {S_IDLE, S_HDR, S_WR, S_DRAIN, S_RD, S_ACK} state_t;

  state_t          state_r;
  logic [1:0]      op_r, src_r, dest_r;
  logic [ACW-1:0]  addr_idx_r;
  logic [LW-1:0]   in_cnt_r, rd_cnt_r, beats_s;
  logic [PW-1:0]   wr_ptr_r, rd_ptr_r;
  logic [7:0]      fifo_mem_r [DEPTH];
  logic            rdy_r, done_r;
  logic            empty_s, full_s, in_hs_s, push_s, pop_s, rd_hs_s, out_hs_s;
  logic [AW+7:0]   addr_shift_s;

  assign empty_s      = (wr_ptr_r == rd_ptr_r);
  assign full_s       = (wr_ptr_r[PW-1] != rd_ptr_r[PW-1]) && (wr_ptr_r[PW-2:0] == rd_ptr_r[PW-2:0]);
  assign fsm_wr_valid = !empty_s;
  assign in_hs_s      = bus_valid && bus_ready;
  assign push_s       = in_hs_s && (state_r == S_WR);
  assign pop_s        = fsm_wr_valid && fsm_wr_ready;
  assign rd_hs_s      = fsm_rd_valid && fsm_rd_ready;
  assign out_hs_s     = bus_out_valid && bus_out_ready;
  assign fsm_rd_ready = (state_r == S_RD) && (!bus_out_valid || bus_out_ready) && (rd_cnt_r < length);
  // Address arrives LSB first, so each new byte shifts in from the top.
  assign addr_shift_s = {bus_data, address};

  // Beat count implied by the captured header.
  always_comb begin
    beats_s = '0;
    case (op_r)
      OP_RD_KEY: beats_s = LW'(KEY_BEATS);
      OP_RD_TEXT, OP_WR_RES: begin
        if (src_r == 2'd1) begin
          beats_s = LW'(SHA_BEATS);
        end else if (src_r == 2'd2) begin
          beats_s = LW'(AES_BEATS);
        end else begin
          beats_s = '0;
        end
      end
      default: beats_s = '0;
    endcase
  end

  // Inbound ready per state; held low until the first clock after reset.
  always_comb begin
    bus_ready = 1'b0;
    case (state_r)
      S_IDLE, S_HDR: bus_ready = rdy_r;
      S_WR:          bus_ready = !full_s && (in_cnt_r < length);
      default:       bus_ready = 1'b0;
    endcase
  end

  // FIFO head toward the FSM, forced to zero while empty.
  always_comb begin
    if (empty_s) begin
      fsm_wr_data = 8'h00;
    end else begin
      fsm_wr_data = fifo_mem_r[rd_ptr_r[PW-2:0]];
    end
  end

  // FIFO storage.
  always_ff @(posedge clk) begin
    if (push_s) begin
      fifo_mem_r[wr_ptr_r[PW-2:0]] <= bus_data;
    end
  end

`ifdef MEM_CMD_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] tmo_cnt_r;
  logic          err_timeout_r;
  assign err_timeout = err_timeout_r;
`else
  // Watchdog compiled out: the port waits indefinitely.
  assign err_timeout = (TIMEOUT_CYC > 0) ? 1'b0 : 1'b0;
`endif

  // Command FSM, FIFO pointers, ack sequencing and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= S_IDLE;
      op_r <= 2'd0; src_r <= 2'd0; dest_r <= 2'd0;
      addr_idx_r <= '0; in_cnt_r <= '0; rd_cnt_r <= '0;
      wr_ptr_r <= '0; rd_ptr_r <= '0;
      rdy_r <= 1'b0; done_r <= 1'b0;
      bus_out_valid <= 1'b0; bus_out_data <= 8'h00;
      r_w <= 1'b0; ena <= 1'b0; length <= '0; length_valid <= 1'b0;
      address <= '0; address_valid <= 1'b0; ack_req <= 1'b0; ack_id <= 2'd0;
`ifdef MEM_CMD_TIMEOUT_EN
      tmo_cnt_r <= '0; err_timeout_r <= 1'b0;
`endif
    end else begin
      address_valid <= 1'b0;
      length_valid  <= 1'b0;
      rdy_r         <= 1'b1;
`ifdef MEM_CMD_TIMEOUT_EN
      err_timeout_r <= 1'b0;
`endif
      if (push_s) wr_ptr_r <= wr_ptr_r + PW'(1);
      if (pop_s)  rd_ptr_r <= rd_ptr_r + PW'(1);
      // CTRL ack raised in HDR completes while data is moving.
      if ((state_r inside {S_WR, S_DRAIN, S_RD}) && ack_req && ack_grant) ack_req <= 1'b0;
      case (state_r)
        S_IDLE: begin
          if (in_hs_s) begin
            op_r <= bus_data[1:0]; src_r <= bus_data[3:2]; dest_r <= bus_data[5:4];
            addr_idx_r <= '0;
            state_r <= S_HDR;
          end
        end
        S_HDR: begin
          if (in_hs_s) begin
            address    <= addr_shift_s[AW+7:8];
            addr_idx_r <= addr_idx_r + ACW'(1);
            if (addr_idx_r == ACW'(ADDR_BYTES - 1)) begin
              if ((op_r == OP_HASH) || (beats_s == '0)) begin
                state_r <= S_IDLE;
              end else begin
                address_valid <= 1'b1; length_valid <= 1'b1; length <= beats_s;
                ena <= 1'b1; r_w <= (op_r != OP_WR_RES);
                ack_req <= 1'b1; ack_id <= ACK_CTRL;
                in_cnt_r <= '0; rd_cnt_r <= '0; done_r <= 1'b0;
                state_r <= (op_r == OP_WR_RES) ? S_WR : S_RD;
              end
            end
          end
        end
        S_WR: begin
          if (push_s) in_cnt_r <= in_cnt_r + LW'(1);
          if (txn_done) done_r <= 1'b1;
          if (in_cnt_r == length) state_r <= S_DRAIN;
        end
        S_DRAIN: begin
          // txn_done may be a pulse, so it is remembered until the ack can go out.
          if ((done_r || txn_done) && empty_s && !ack_req) begin
            ena <= 1'b0; ack_req <= 1'b1; ack_id <= src_r;
            state_r <= S_ACK;
          end else if (txn_done) begin
            done_r <= 1'b1;
          end
        end
        S_RD: begin
          if (rd_hs_s) begin
            bus_out_data  <= fsm_rd_data;
            bus_out_valid <= 1'b1;
            rd_cnt_r      <= rd_cnt_r + LW'(1);
          end else if (out_hs_s) begin
            bus_out_valid <= 1'b0;
          end
          if ((rd_cnt_r == length) && !bus_out_valid && !ack_req) begin
            ena <= 1'b0; ack_req <= 1'b1; ack_id <= dest_r;
            state_r <= S_ACK;
          end
        end
        S_ACK: begin
          if (ack_grant) begin
            ack_req <= 1'b0;
            state_r <= S_IDLE;
          end
        end
        default: state_r <= S_IDLE;
      endcase
`ifdef MEM_CMD_TIMEOUT_EN
      // Watchdog overrides the FSM when it fires.
      if (state_r inside {S_WR, S_DRAIN, S_RD}) begin
        if (in_hs_s || pop_s || rd_hs_s || out_hs_s || txn_done) begin
          tmo_cnt_r <= '0;
        end else if (tmo_cnt_r == TW'(TIMEOUT_CYC - 1)) begin
          tmo_cnt_r <= '0; err_timeout_r <= 1'b1;
          wr_ptr_r <= '0; rd_ptr_r <= '0; bus_out_valid <= 1'b0;
          ena <= 1'b0; ack_req <= 1'b0; state_r <= S_IDLE;
        end else begin
          tmo_cnt_r <= tmo_cnt_r + TW'(1);
        end
      end else begin
        tmo_cnt_r <= '0;
      end
`endif
    end
  end

endmodule

// File: tb/tb_mem_cmd_port_p.sv
// Directed scoreboard bench for mem_cmd_port_p (RD_KEY, WR_RES, HASH_OP, RD_TEXT, ack hold, watchdog, reset).
module tb_mem_cmd_port_p;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, bus_valid, bus_ready, bus_out_valid, bus_out_ready;
  logic fsm_wr_valid, fsm_wr_ready, fsm_rd_valid, fsm_rd_ready, txn_done;
  logic r_w, ena, length_valid, address_valid, ack_req, ack_grant, err_timeout;
  logic [7:0] bus_data, bus_out_data, fsm_wr_data, fsm_rd_data;
  logic [5:0] length;
  logic [23:0] address;
  logic [1:0] ack_id;

  int errors = 0;
  int checks = 0;
  logic [7:0] exp_q[$];

  mem_cmd_port_p #(.TIMEOUT_CYC(16)) dut (
    .clk(clk), .rst_n(rst_n), .bus_valid(bus_valid), .bus_data(bus_data), .bus_ready(bus_ready),
    .bus_out_valid(bus_out_valid), .bus_out_data(bus_out_data), .bus_out_ready(bus_out_ready),
    .fsm_wr_valid(fsm_wr_valid), .fsm_wr_data(fsm_wr_data), .fsm_wr_ready(fsm_wr_ready),
    .fsm_rd_valid(fsm_rd_valid), .fsm_rd_data(fsm_rd_data), .fsm_rd_ready(fsm_rd_ready),
    .txn_done(txn_done), .r_w(r_w), .ena(ena), .length(length), .length_valid(length_valid),
    .address(address), .address_valid(address_valid), .ack_req(ack_req), .ack_id(ack_id),
    .ack_grant(ack_grant), .err_timeout(err_timeout)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk(tag, {bus_ready, bus_out_valid, bus_out_data, fsm_wr_valid, fsm_wr_data, fsm_rd_ready, r_w, ena,
              length, length_valid, address_valid, ack_req, ack_id, err_timeout, address}, 64'd0);
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit ok = 1'b0;
    bus_valid = 1'b1; bus_data = b;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (bus_ready) ok = 1'b1;
      step();
    end
    bus_valid = 1'b0;
    if (!ok) chk("send_timeout", 64'd0, 64'd1);
  endtask

  task automatic send_cmd(input logic [7:0] h, input logic [7:0] a0, input logic [7:0] a1, input logic [7:0] a2);
    send_byte(h); send_byte(a0); send_byte(a1); send_byte(a2);
  endtask

  task automatic wait_ack(input string tag, input logic [1:0] id);
    bit seen = 1'b0;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge clk);
      if (ack_req) seen = 1'b1;
    end
    chk({tag, "_req"}, seen, 1);
    chk({tag, "_id"}, ack_id, id);
    step();
  endtask

  task automatic grant();
    ack_grant = 1'b1; step(); ack_grant = 1'b0;
  endtask

  task automatic rd_stream(input int n, input logic [7:0] base, input bit toggle);
    int got = 0;
    int sup = 0;
    int extra = 0;
    fsm_rd_valid = 1'b1; fsm_rd_data = base; bus_out_ready = 1'b1;
    for (int c = 0; c < 600 && got < n; c++) begin
      @(negedge clk);
      if (bus_out_valid && bus_out_ready) begin
        if (exp_q.size() == 0) chk("rd_extra_byte", bus_out_data, 64'hFFFF);
        else chk("rd_data", bus_out_data, exp_q.pop_front());
        got++;
      end
      if (fsm_rd_valid && fsm_rd_ready) begin
        exp_q.push_back(8'(base + sup));
        sup++;
      end
      step();
      fsm_rd_data = 8'(base + sup);
      if (toggle) bus_out_ready = ~bus_out_ready;
    end
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (fsm_rd_ready || bus_out_valid) extra++;
      step();
    end
    fsm_rd_valid = 1'b0; bus_out_ready = 1'b1;
    chk("rd_count", got, n);
    chk("rd_no_extra", extra, 0);
    chk("rd_q_empty", exp_q.size(), 0);
  endtask

  initial begin
    int k, delivered, idle, tmo_at;
    bit seen;
    rst_n = 1'b0; bus_valid = 1'b0; bus_data = 8'h00; bus_out_ready = 1'b1;
    fsm_wr_ready = 1'b0; fsm_rd_valid = 1'b0; fsm_rd_data = 8'h00; txn_done = 1'b0; ack_grant = 1'b0;
    #12;
    chk_all_zero("reset_outputs");
    @(negedge clk); rst_n = 1'b1;
    step();
    chk("idle_ready", bus_ready, 1);

    // RD_KEY, dest=MEM
    send_cmd(8'h00, 8'h56, 8'h34, 8'h12);
    chk("rdkey_pulses", {address_valid, length_valid, r_w, ena}, 4'b1111);
    chk("rdkey_addr", address, 24'h123456);
    chk("rdkey_len", length, 32);
    chk("rdkey_ctrl_ack", {ack_req, ack_id}, 3'b111);
    step();
    chk("rdkey_pulse_width", {address_valid, length_valid}, 2'b00);
    grant();
    rd_stream(32, 8'h00, 1'b0);
    wait_ack("rdkey_ack", 2'd0);
    chk("rdkey_ena_off", ena, 0);
    grant();
    chk("rdkey_idle", {bus_ready, ack_req}, 2'b10);

    // WR_RES from AES with the FSM stalled
    send_cmd(8'h0A, 8'h01, 8'h02, 8'h03);
    chk("wr_pulses", {address_valid, length_valid, r_w, ena, bus_ready}, 5'b11011);
    chk("wr_len", length, 16);
    grant();
    fsm_wr_ready = 1'b0; k = 0; bus_valid = 1'b1; bus_data = 8'hA0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (bus_valid && bus_ready) begin exp_q.push_back(8'(8'hA0 + k)); k++; end
      step();
      bus_data = 8'(8'hA0 + k);
    end
    chk("wr_full_count", k, 4);
    chk("wr_full_ready", bus_ready, 0);
    chk("wr_head", {fsm_wr_valid, fsm_wr_data}, 9'h1A0);
    fsm_wr_ready = 1'b1; delivered = 0;
    for (int c = 0; c < 200 && delivered < 16; c++) begin
      @(negedge clk);
      if (fsm_wr_valid && fsm_wr_ready) begin
        if (exp_q.size() == 0) chk("wr_extra_byte", fsm_wr_data, 64'hFFFF);
        else chk("wr_data", fsm_wr_data, exp_q.pop_front());
        delivered++;
      end
      if (bus_valid && bus_ready) begin exp_q.push_back(8'(8'hA0 + k)); k++; end
      step();
      bus_valid = (k < 16); bus_data = 8'(8'hA0 + k);
    end
    bus_valid = 1'b0;
    chk("wr_delivered", delivered, 16);
    step();
    chk("wr_drain_wait", {ack_req, bus_ready, fsm_wr_valid}, 3'b000);
    txn_done = 1'b1; step(); txn_done = 1'b0;
    wait_ack("wr_ack", 2'd2);
    chk("wr_ena_off", ena, 0);
    grant();

    // HASH_OP and N=0 commands are dropped silently
    send_cmd(8'h07, 8'h11, 8'h22, 8'h33);
    chk("hash_quiet", {address_valid, length_valid, ack_req, ena}, 4'b0000);
    step();
    chk("hash_idle", {bus_ready, ack_req}, 2'b10);
    send_cmd(8'h01, 8'h11, 8'h22, 8'h33);
    chk("zero_n_quiet", {address_valid, length_valid, ack_req, ena}, 4'b0000);

    // RD_TEXT from SHA, dest=AES, toggling ready, CTRL ack left pending
    send_cmd(8'h25, 8'h10, 8'h20, 8'h30);
    chk("rdtext_addr", address, 24'h302010);
    chk("rdtext_len", length, 32);
    rd_stream(32, 8'h40, 1'b1);
    chk("rdtext_ctrl_pending", {ack_req, ack_id}, 3'b111);
    step();
    chk("rdtext_ctrl_still", {ack_req, ack_id}, 3'b111);
    grant();
    wait_ack("rdtext_ack", 2'd2);
    for (int c = 0; c < 10; c++) begin
      step();
      chk("ack_hold", {ack_req, ack_id}, 3'b110);
    end
    grant();
    chk("ack_release_idle", {ack_req, bus_ready}, 2'b01);

`ifdef MEM_CMD_TIMEOUT_EN
    // WR_RES from SHA stalls after 5 bytes
    send_cmd(8'h06, 8'h00, 8'h00, 8'h00);
    grant();
    fsm_wr_ready = 1'b1; k = 0; idle = 0; tmo_at = 0; seen = 1'b0;
    bus_valid = 1'b1; bus_data = 8'h55;
    for (int c = 0; c < 100 && !seen; c++) begin
      @(negedge clk);
      if (err_timeout) begin
        seen = 1'b1; tmo_at = idle + 1;
      end else begin
        if ((bus_valid && bus_ready) || (fsm_wr_valid && fsm_wr_ready)) idle = 0;
        else idle++;
        if (bus_valid && bus_ready) k++;
      end
      step();
      bus_valid = (k < 5);
    end
    bus_valid = 1'b0;
    chk("tmo_bytes", k, 5);
    chk("tmo_seen", seen, 1);
    chk("tmo_cycle", tmo_at, 16);
    chk("tmo_after", {err_timeout, fsm_wr_valid, ena, ack_req, bus_ready}, 5'b00001);
`else
    chk("no_watchdog", err_timeout, 0);
`endif

    // Asynchronous reset in the middle of a read
    send_cmd(8'h00, 8'h01, 8'h02, 8'h03);
    grant();
    bus_out_ready = 1'b0; fsm_rd_valid = 1'b1; fsm_rd_data = 8'h77;
    step(); step(); step();
    chk("pre_reset_busy", {bus_out_valid, ena}, 2'b11);
    #2 rst_n = 1'b0;
    #1 chk_all_zero("async_reset");
    fsm_rd_valid = 1'b0; bus_out_ready = 1'b1;
    @(negedge clk); rst_n = 1'b1;
    step();
    chk("post_reset_idle", {bus_ready, ena, bus_out_valid}, 3'b100);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mem_cmd_port_p.md
# mem_cmd_port_p

Parametrised memory-side command port for the crypto NoC. It parses a command (header byte plus ADDR_BYTES little-endian address bytes) from the 8-bit data bus, then does one of three things: streams write-result data into the transaction FSM through a DEPTH-entry FIFO, streams read data from the FSM onto the bus, or drops the command. It issues acknowledgements on the shared ack bus and sits between the NoC data bus and the memory transaction FSM / QSPI path.

## Interface
Parameters:
- ADDR_BYTES, 3: address bytes following the header; address width is 8*ADDR_BYTES.
- KEY_BEATS, 32: bytes moved for RD_KEY.
- SHA_BEATS, 32: bytes for RD_TEXT/WR_RES when source=SHA.
- AES_BEATS, 16: bytes for RD_TEXT/WR_RES when source=AES.
- DEPTH, 4: write FIFO entries; must be a power of two and at least 2.
- TIMEOUT_CYC, 1024: idle-cycle limit; used only with MEM_CMD_TIMEOUT_EN.

Ports (LW = $clog2(max beats + 1)):
- clk  in  1  clock
- rst_n  in  1  reset; asynchronous, active-low
- bus_valid  in  1  inbound byte valid
- bus_data  in  8  inbound byte
- bus_ready  out  1  inbound byte accepted
- bus_out_valid  out  1  outbound byte valid
- bus_out_data  out  8  outbound byte
- bus_out_ready  in  1  host accepts outbound byte
- fsm_wr_valid  out  1  FIFO head valid toward FSM
- fsm_wr_data  out  8  FIFO head byte
- fsm_wr_ready  in  1  FSM pops FIFO head
- fsm_rd_valid  in  1  FSM read byte valid
- fsm_rd_data  in  8  FSM read byte
- fsm_rd_ready  out  1  port accepts FSM byte
- txn_done  in  1  FSM finished the memory transaction
- r_w  out  1  1 = read (RD_KEY/RD_TEXT), 0 = write
- ena  out  1  transaction active
- length  out  LW  byte count of the transaction
- length_valid  out  1  one-cycle pulse
- address  out  8*ADDR_BYTES  captured address
- address_valid  out  1  one-cycle pulse
- ack_req  out  1  ack request, held until granted
- ack_id  out  2  ack target (MEM=0, SHA=1, AES=2, CTRL=3)
- ack_grant  in  1  ack bus grant
- err_timeout  out  1  one-cycle pulse on watchdog abort

## Operation
- Header byte fields: [7] enc_dec, [6] reserved, [5:4] dest, [3:2] source, [1:0] opcode.
- Opcodes: RD_KEY=0, RD_TEXT=1, WR_RES=2, HASH_OP=3.
- N (beat count): RD_KEY gives KEY_BEATS. RD_TEXT and WR_RES give SHA_BEATS if source=1, AES_BEATS if source=2, otherwise 0.
- States:
  - IDLE → HDR. bus_ready=1 in IDLE; the accepted byte is captured as the header.
  - HDR: accepts ADDR_BYTES address bytes, least-significant byte first, into address.
  - HDR on last address byte, HASH_OP or N=0: go to IDLE; no pulses, no ack.
  - HDR on last address byte, otherwise: next cycle pulse address_valid and length_valid; length=N; ena=1; r_w set; raise ack_req with ack_id=CTRL; go to WR (WR_RES) or RD.
- WR:
  - bus_ready = !full && in_cnt<N. Each handshake pushes one byte.
  - fsm_wr_valid = !empty.
  - When in_cnt==N, go to DRAIN.
- DRAIN: wait for FIFO empty and txn_done. Then ena=0, ack_req=1 with ack_id=source, go to ACK.
- RD:
  - Single registered output stage: fsm_rd_ready = (!bus_out_valid || bus_out_ready) && rd_cnt<N.
  - Each FSM handshake loads bus_out_data and sets bus_out_valid.
  - Once rd_cnt==N and the output stage is empty: ena=0, ack_req=1 with ack_id=dest, go to ACK.
- ACK: hold ack_req/ack_id until ack_grant, then drop ack_req and go to IDLE.
- The CTRL ack raised in HDR must complete before the end-of-transfer ack is raised. If it is still pending at end of transfer, the end-of-transfer ack waits.
- Counters are LW bits wide and saturate at N; they never wrap.

## Timing
- Reset values: every output is 0, including address, length and ack_id. FIFO is empty; state is IDLE.
- address_valid/length_valid rise 1 cycle after the last address-byte handshake.
- The first WR bus_ready is the same cycle as those pulses.
- Bus→FSM latency: a byte pushed at cycle t is visible on fsm_wr_valid at t+1.
- FSM→bus latency: 1 cycle.
- Simultaneous FIFO push and pop: count unchanged; push is allowed while full only if pop does not bypass (no bypass — full blocks push).
- FIFO pointers are log2(DEPTH)+1 bits and wrap naturally.
- Reset mid-operation: immediate abort, FIFO flushed, no ack issued.

## Configuration
- MEM_CMD_TIMEOUT_EN defined:
  - A counter increments in WR, DRAIN and RD, and clears on any bus or FSM handshake or on txn_done.
  - When it reaches TIMEOUT_CYC: pulse err_timeout, flush FIFO, clear bus_out_valid, ena=0, drop any pending ack, go to IDLE.
- Undefined: counter logic is absent, err_timeout is tied to 0, and the port waits indefinitely.

## Test plan
- RD_KEY: header 0x00, address bytes 0x56,0x34,0x12 → address=0x123456, length=32, r_w=1. FSM supplies 32 bytes 0x00..0x1F → appear in order on bus; CTRL ack, then ack_id=dest.
- WR_RES, source=AES: header 0x0A + 3 address bytes; 16 bytes with fsm_wr_ready=0 → bus_ready drops after 4 bytes (DEPTH=4). Release ready and pulse txn_done → all 16 bytes delivered; ack_id=2.
- HASH_OP header 0x07 + address → returns to IDLE; no valid pulses, no ack_req.
- RD_TEXT, source=SHA, with bus_out_ready toggling every cycle → exactly 32 bytes, none duplicated or dropped.
- ack_grant withheld 10 cycles → ack_req stays high with stable ack_id; IDLE is entered 1 cycle after grant.
- With MEM_CMD_TIMEOUT_EN and TIMEOUT_CYC=16: WR_RES stalled after 5 bytes → err_timeout pulse at the 16th idle cycle, FIFO empty, IDLE. Async reset mid-RD → all outputs 0 immediately.
